// File: rtl/tb_obi_initiator_if.sv
// rtl/tb_obi_initiator_if.sv - command, response and OBI bus signals of the bench OBI initiator
//
// Purpose: bundles the three streams seen by tb_obi_initiator.
//   cmd_*  : command stream (cmd_valid/cmd_ready handshake, addr, we, be, wdata)
//   rsp_*  : response stream (rsp_valid pulse, rdata, we), no backpressure
//   obi_*  : OBI address phase (req, addr, we, be, wdata) and response phase
//            (gnt, rdata, rvalid)
// Modports:
//   master : the initiator view (drives cmd_ready, rsp_*, obi address phase)
//   slave  : the environment view (drives commands, grant and responses)

interface tb_obi_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_we;
    logic [3:0]  cmd_be;
    logic [31:0] cmd_wdata;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_we;

    logic        obi_req;
    logic [31:0] obi_addr;
    logic        obi_we;
    logic [3:0]  obi_be;
    logic [31:0] obi_wdata;
    logic        obi_gnt;
    logic [31:0] obi_rdata;
    logic        obi_rvalid;

    modport master (
        input  cmd_valid, cmd_addr, cmd_we, cmd_be, cmd_wdata,
        input  obi_gnt, obi_rdata, obi_rvalid,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_we,
        output obi_req, obi_addr, obi_we, obi_be, obi_wdata
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_we, cmd_be, cmd_wdata,
        output obi_gnt, obi_rdata, obi_rvalid,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_we,
        input  obi_req, obi_addr, obi_we, obi_be, obi_wdata
    );
endinterface

// File: rtl/tb_obi_initiator.sv
// rtl/tb_obi_initiator.sv - bench OBI initiator turning a command stream into pipelined OBI requests
//
// Purpose: accepts commands on a valid/ready stream, issues them as registered
// OBI address-phase requests, keeps up to MAX_OUTSTANDING granted requests in
// flight and returns each completion as a one-cycle response pulse. Sticky
// flags report an rvalid with nothing outstanding and, optionally, a stall
// watchdog expiry.
// Parameters:
//   MAX_OUTSTANDING : granted requests awaiting rvalid (1..8)
//   TIMEOUT_CYCLES  : watchdog limit, used only with TB_OBI_INITIATOR_TIMEOUT_EN
// Optional feature macro: TB_OBI_INITIATOR_TIMEOUT_EN (watchdog; when undefined
// err_timeout is tied low).
// Ports:
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   bus (master)     : cmd_*, rsp_*, obi_* signals, see tb_obi_initiator_if
//   err_unexpected   : sticky, rvalid seen with zero outstanding
//   err_timeout      : sticky, watchdog expired

module tb_obi_initiator #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                clock,
    input  logic                reset,
    tb_obi_initiator_if.master  bus,
    output logic                err_unexpected,
    output logic                err_timeout
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic {IDLE, REQ} state_e;

    state_e        state_q, state_d;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          we_q;
    logic [3:0]    be_q;

    logic [CW-1:0] outst_q;
    logic [CW-1:0] outst_d;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic          we_fifo_q [MAX_OUTSTANDING];

    logic          rsp_valid_q;
    logic          rsp_we_q;
    logic [31:0]   rsp_rdata_q;
    logic          err_unexpected_q;

    logic          gnt_fire;
    logic          rv_counted;
    logic          accept;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign bus.obi_req   = (state_q == REQ);
    assign bus.obi_addr  = addr_q;
    assign bus.obi_we    = we_q;
    assign bus.obi_be    = be_q;
    assign bus.obi_wdata = wdata_q;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_we    = rsp_we_q;
    assign err_unexpected = err_unexpected_q;

    assign gnt_fire   = bus.obi_req && bus.obi_gnt;
    // An rvalid with nothing outstanding is an error, not a completion.
    assign rv_counted = bus.obi_rvalid && (outst_q != '0);
    assign outst_d    = outst_q + CW'(gnt_fire) - CW'(rv_counted);

    // A new command may only be accepted if the address phase is free this
    // cycle and the count after this cycle leaves room for one more grant.
    assign bus.cmd_ready = !reset && (!bus.obi_req || bus.obi_gnt)
                           && (outst_d < CW'(MAX_OUTSTANDING));
    assign accept = bus.cmd_valid && bus.cmd_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = REQ;
            REQ:  if (bus.obi_gnt && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= bus.cmd_addr;
                wdata_q <= bus.cmd_wdata;
                we_q    <= bus.cmd_we;
                be_q    <= bus.cmd_be;
            end
        end
    end

    // Outstanding count and the in-order write-enable FIFO share occupancy:
    // push on grant, pop on counted rvalid.
    always_ff @(posedge clock) begin
        if (reset) begin
            outst_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                we_fifo_q[i] <= 1'b0;
            end
        end else begin
            outst_q <= outst_d;
            if (gnt_fire) begin
                we_fifo_q[wr_ptr_q] <= bus.obi_we;
                wr_ptr_q            <= ptr_inc(wr_ptr_q);
            end
            if (rv_counted) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid_q      <= 1'b0;
            rsp_we_q         <= 1'b0;
            rsp_rdata_q      <= '0;
            err_unexpected_q <= 1'b0;
        end else begin
            rsp_valid_q <= rv_counted;
            if (rv_counted) begin
                rsp_rdata_q <= bus.obi_rdata;
                rsp_we_q    <= we_fifo_q[rd_ptr_q];
            end
            if (bus.obi_rvalid && (outst_q == '0)) begin
                err_unexpected_q <= 1'b1;
            end
        end
    end

`ifdef TB_OBI_INITIATOR_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WW-1:0] wd_q;
    logic          err_timeout_q;
    logic          wd_stall;

    // Waiting either for a grant or for a response counts as a stall.
    assign wd_stall = (bus.obi_req && !bus.obi_gnt)
                      || ((outst_q != '0) && !bus.obi_rvalid);
    assign err_timeout = err_timeout_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            wd_q          <= '0;
            err_timeout_q <= 1'b0;
        end else if (gnt_fire || rv_counted) begin
            wd_q <= '0;
        end else if (wd_q == WW'(TIMEOUT_CYCLES)) begin
            err_timeout_q <= 1'b1;
        end else if (wd_stall) begin
            wd_q <= wd_q + 1'b1;
        end
    end
`else
    logic timeout_unused;
    assign timeout_unused = ^TIMEOUT_CYCLES;
    assign err_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_tb_obi_initiator.sv
// tb/tb_tb_obi_initiator.sv - scoreboard bench for tb_obi_initiator against a small OBI RAM responder

module tb_tb_obi_initiator;

    localparam int MAXO = 2;
    localparam int TMO  = 16;
`ifdef TB_OBI_INITIATOR_TIMEOUT_EN
    localparam logic EXP_TIMEOUT = 1'b1;
`else
    localparam logic EXP_TIMEOUT = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic err_unexpected;
    logic err_timeout;

    always #5 clock = ~clock;

    tb_obi_initiator_if bus();

    tb_obi_initiator #(
        .MAX_OUTSTANDING(MAXO),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .bus            (bus),
        .err_unexpected (err_unexpected),
        .err_timeout    (err_timeout)
    );

    typedef struct {
        logic        we;
        logic [31:0] rdata;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   run   = 0;
    int   max_run = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // OBI RAM responder: combinational grant, one-cycle rvalid when enabled.
    logic        gnt_en = 1'b1;
    logic        rv_en  = 1'b1;
    logic        inj_rv = 1'b0;
    logic        rv_q   = 1'b0;
    logic [31:0] rd_q   = '0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] pend_q[$];
    logic [31:0] r_word;
    logic [31:0] r_old;

    assign bus.obi_gnt    = bus.obi_req & gnt_en;
    assign bus.obi_rvalid = rv_q | inj_rv;
    assign bus.obi_rdata  = rd_q;

    always @(posedge clock) begin
        if (reset) begin
            rv_q <= 1'b0;
            pend_q.delete();
        end else begin
            if (bus.obi_req && bus.obi_gnt) begin
                r_word = bus.obi_addr >> 2;
                r_old  = mem.exists(r_word) ? mem[r_word] : 32'h0;
                if (bus.obi_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (bus.obi_be[b]) r_old[8*b +: 8] = bus.obi_wdata[8*b +: 8];
                    end
                    mem[r_word] = r_old;
                    pend_q.push_back(32'h0);
                end else begin
                    pend_q.push_back(r_old);
                end
            end
            if (rv_en && pend_q.size() > 0) begin
                rd_q <= pend_q.pop_front();
                rv_q <= 1'b1;
            end else begin
                rv_q <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a response pulse appears.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && bus.rsp_valid) begin
            run++;
            if (run > max_run) max_run = run;
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got rdata=%h we=%b with no response expected",
                         bus.rsp_rdata, bus.rsp_we);
            end else begin
                e = sb_q.pop_front();
                check("rsp_rdata", bus.rsp_rdata, e.rdata);
                check("rsp_we", {31'b0, bus.rsp_we}, {31'b0, e.we});
                if (e.lat >= 0) check("rsp_latency", cyc - e.acc, e.lat);
            end
        end else begin
            run = 0;
        end
    end

    task automatic send(input logic [31:0] a, input logic we, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input int lat,
                        input bit push, output int waits);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_we    = we;
        bus.cmd_be    = be;
        bus.cmd_wdata = wd;
        #1;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clock);
            #1;
            n++;
        end
        waits = n;
        if (!bus.cmd_ready) begin
            total++;
            bad++;
            $display("FAIL cmd_accept_timeout: got cmd_ready=0 after %0d cycles expected 1", n);
        end else if (push) begin
            sb_q.push_back('{we, exp_rd, lat, cyc});
        end
        @(negedge clock);
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        int w;
        int wsum;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_we    = 1'b0;
        bus.cmd_be    = '0;
        bus.cmd_wdata = '0;
        mem[32'h100 >> 2] = 32'hDEADBEEF;
        for (int i = 0; i < 8; i++) mem[(32'h200 >> 2) + i] = 32'hA5000000 | i;

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_obi_req", {31'b0, bus.obi_req}, 32'h0);
        check("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'h0);
        check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
        check("rst_err_unexpected", {31'b0, err_unexpected}, 32'h0);
        check("rst_obi_fields", {bus.obi_addr ^ bus.obi_wdata}
              | {27'b0, bus.obi_we, bus.obi_be}, 32'h0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_cmd_ready", {31'b0, bus.cmd_ready}, 32'h1);

        // Single read, 3-cycle latency, obi_req in the cycle after accept
        send(32'h100, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, 3, 1'b1, w);
        check("rd_obi_req_t1", {31'b0, bus.obi_req}, 32'h1);
        check("rd_obi_addr_t1", bus.obi_addr, 32'h100);
        repeat (4) @(negedge clock);

        // Partial write then read-back, in order
        send(32'h40, 1'b1, 4'b0011, 32'h12345678, 32'h0, -1, 1'b1, w);
        send(32'h40, 1'b0, 4'hF, 32'h0, 32'h00005678, -1, 1'b1, w);
        repeat (4) @(negedge clock);

        // Eight back-to-back reads, zero-wait
        max_run = 0;
        wsum = 0;
        for (int i = 0; i < 8; i++) begin
            send(32'h200 + 4 * i, 1'b0, 4'hF, 32'h0, 32'hA5000000 | i, -1, 1'b1, w);
            wsum += w;
        end
        check("b2b_ready_waits", wsum, 0);
        repeat (4) @(negedge clock);
        check("b2b_rsp_run", {31'b0, (max_run >= 8)}, 32'h1);

        // Grant held low for 5 cycles
        gnt_en = 1'b0;
        send(32'h300, 1'b1, 4'b1010, 32'hCAFEF00D, 32'h0, 8, 1'b1, w);
        for (int i = 0; i < 5; i++) begin
            check("stall_obi_req", {31'b0, bus.obi_req}, 32'h1);
            check("stall_obi_addr", bus.obi_addr, 32'h300);
            check("stall_obi_wdata", bus.obi_wdata, 32'hCAFEF00D);
            check("stall_obi_we_be", {27'b0, bus.obi_we, bus.obi_be}, {27'b0, 1'b1, 4'b1010});
            check("stall_cmd_ready", {31'b0, bus.cmd_ready}, 32'h0);
            @(negedge clock);
        end
        gnt_en = 1'b1;
        repeat (4) @(negedge clock);

        // Outstanding limit: responses held, count reaches MAX
        rv_en = 1'b0;
        send(32'h100, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, -1, 1'b1, w);
        send(32'h200, 1'b0, 4'hF, 32'h0, 32'hA5000000, -1, 1'b1, w);
        for (int i = 0; i < 3; i++) begin
            check("full_cmd_ready", {31'b0, bus.cmd_ready}, 32'h0);
            @(negedge clock);
        end
        rv_en = 1'b1;
        send(32'h204, 1'b0, 4'hF, 32'h0, 32'hA5000001, -1, 1'b1, w);
        check("full_waited", {31'b0, (w > 0)}, 32'h1);
        repeat (5) @(negedge clock);

        // Unexpected rvalid while idle, then reset clears the flag
        check("unexp_before", {31'b0, err_unexpected}, 32'h0);
        inj_rv = 1'b1;
        @(negedge clock);
        inj_rv = 1'b0;
        check("unexp_flag", {31'b0, err_unexpected}, 32'h1);
        repeat (2) @(negedge clock);
        check("unexp_sticky", {31'b0, err_unexpected}, 32'h1);
        reset = 1'b1;
        @(negedge clock);
        check("rst2_cmd_ready", {31'b0, bus.cmd_ready}, 32'h0);
        check("rst2_err_unexpected", {31'b0, err_unexpected}, 32'h0);
        check("rst2_obi_req", {31'b0, bus.obi_req}, 32'h0);
        reset = 1'b0;
        @(negedge clock);
        send(32'h100, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, 3, 1'b1, w);
        repeat (4) @(negedge clock);

        // Watchdog: grant never given
        gnt_en = 1'b0;
        send(32'h100, 1'b0, 4'hF, 32'h0, 32'h0, -1, 1'b0, w);
        repeat (TMO + 4) @(negedge clock);
        check("err_timeout", {31'b0, err_timeout}, {31'b0, EXP_TIMEOUT});
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        gnt_en = 1'b1;
        @(negedge clock);
        check("timeout_cleared", {31'b0, err_timeout}, 32'h0);

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clock);
        check("sb_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
